alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, registered ALU for the CPU datapath with a start/done handshake. It keeps the single-cycle operation set of the 16-bit ripple ALU: AND, OR, ADD/SUB with the BNegate convention, SLT, plus XOR and NOR. It adds two multi-cycle operations: shift-add unsigned multiply and restoring unsigned divide. It sits between the register file read ports and the writeback mux; the control unit stalls on `Busy`.

## Interface

**Parameters**
- `WIDTH`, 16, operand/result width in bits (≥4).

**Ports**
- `Clock`, in, 1, single clock, all state updates on rising edge.
- `Reset`, in, 1, asynchronous, active-high; clears all state and outputs.
- `Start`, in, 1, request; sampled on a rising edge only when `Busy`=0.
- `A`, in, WIDTH, operand A; captured when Start is accepted.
- `B`, in, WIDTH, operand B; captured when Start is accepted.
- `Operacioni`, in, 3, operation select; captured when Start is accepted.
- `BNegate`, in, 1, subtract select for ADD; captured when Start is accepted.
- `Busy`, out, 1, a multi-cycle operation is in progress.
- `Done`, out, 1, one-cycle pulse; result and flags valid from this cycle.
- `Result`, out, WIDTH, primary result.
- `ResultHi`, out, WIDTH, upper product (MUL), remainder (DIV), 0 otherwise.
- `Zero`, out, 1, `Result`==0 (low word only).
- `Overflow`, out, 1, see per-op rules.
- `CarryOut`, out, 1, carry out of the MSB for ADD/SUB/SLT, 0 otherwise.

## Operation

**Opcode map**
- 000 AND: A & B.
- 001 OR: A | B.
- 010 ADD/SUB: A + (B ^ {WIDTH{BNegate}}) + BNegate.
- 011 SLT: always subtracts, ignoring BNegate. Result = {0…, sign(A−B) ^ Overflow(A−B)}, i.e. signed A<B.
- 100 MUL: unsigned A×B, 2·WIDTH-bit product split as {ResultHi, Result}.
- 101 DIV: unsigned; quotient goes to Result, remainder to ResultHi.
- 110 XOR: A ^ B.
- 111 NOR: ~(A | B).

**Flags**
- ADD/SUB/SLT: CarryOut = carry out of bit WIDTH−1 (SUB: 1 means no borrow). Overflow = carry into MSB XOR carry out of MSB.
- MUL: Overflow = (ResultHi != 0); CarryOut = 0.
- DIV: Overflow = 1 only on divide-by-zero; CarryOut = 0.
- Logic ops: Overflow = CarryOut = 0.

**FSM states: IDLE, MUL_RUN, DIV_RUN**
- IDLE + Start, single-cycle op or DIV with B=0: compute and register outputs on the accepting edge; Done=1 for the next cycle; stay in IDLE.
- IDLE + Start, MUL: load multiplicand, multiplier and zeroed accumulator; counter=WIDTH; go to MUL_RUN; Busy=1.
- IDLE + Start, DIV with B≠0: load dividend, divisor and zeroed remainder; counter=WIDTH; go to DIV_RUN; Busy=1.
- MUL_RUN, each edge: if multiplier LSB is set, add multiplicand into the accumulator high half; shift {carry, acc, multiplier} right by 1; decrement counter.
- DIV_RUN, each edge: shift {rem, quotient} left by 1; trial-subtract the divisor; if non-negative, keep the difference and set quotient LSB; decrement counter.
- MUL_RUN/DIV_RUN with counter reaching 0: register Result, ResultHi and flags; pulse Done; clear Busy; return to IDLE.

**Boundary rules**
- Start while Busy=1 is ignored; no queuing.
- Start on the same edge that Done deasserts is accepted normally.
- Divide-by-zero: Result = all ones, ResultHi = A, Overflow=1, Zero=0; single-cycle latency.
- Outputs hold their last values until the next completion; they do not change while Busy.
- Reset asserted mid-operation aborts immediately: state IDLE, counter 0. Busy, Done, Result, ResultHi, Zero, Overflow and CarryOut are all 0, and no Done is produced for the aborted op.

## Timing

- Reset values: all outputs 0, FSM in IDLE.
- Single-cycle ops (including DIV by zero): Start sampled at edge k; outputs valid and Done=1 from edge k until edge k+1.
- MUL/DIV: Start at edge k; Busy=1 from edge k; Done=1 and Busy=0 from edge k+WIDTH+1 for one cycle. Total latency is WIDTH+1 cycles (17 at WIDTH=16).
- Done is never high for two consecutive cycles without a new Start in between.
- Operand inputs may change freely after the accepting edge.

## Test plan

- ADD 0x7FFF + 0x0001 (Operacioni=010, BNegate=0) -> Result 0x8000, Overflow=1, CarryOut=0, Zero=0, Done one cycle after Start.
- SUB 0x0005 − 0x0005 (BNegate=1) -> Result 0x0000, Zero=1, CarryOut=1, Overflow=0. SLT A=0xFFFD (−3), B=0x0002 -> Result 0x0001.
- MUL 0x0100 × 0x0100 -> Result 0x0000, ResultHi 0x0001, Zero=1, Overflow=1. Done exactly 17 cycles after Start; a Start pulse at cycle 5 with different operands is ignored.
- DIV 100 / 7 -> Result 14, ResultHi 2, Overflow=0 after 17 cycles. DIV 0x1234 / 0 -> Result 0xFFFF, ResultHi 0x1234, Overflow=1, Done after 1 cycle.
- Reset asserted asynchronously (between edges) at cycle 6 of a MUL -> Busy, Done and all outputs 0 immediately, no later Done. A fresh ADD 3+4 afterwards -> Result 7, Done after 1 cycle.
- Back-to-back: MUL completes, with Start for XOR 0xF0F0 ^ 0xFFFF in the Done cycle -> accepted; Result 0x0F0F, Done on the following cycle.

Source files
------------

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU: single-cycle logic/arith ops, multi-cycle shift-add MUL and restoring DIV
module alu_seq #(
   parameter int WIDTH = 16
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       Operacioni,
   input  logic             BNegate,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Result,
   output logic [WIDTH-1:0] ResultHi,
   output logic             Zero,
   output logic             Overflow,
   output logic             CarryOut
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SLT = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam logic [2:0] OP_DIV = 3'b101;
   localparam logic [2:0] OP_XOR = 3'b110;
   localparam logic [2:0] OP_NOR = 3'b111;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MUL_RUN = 2'd1,
      DIV_RUN = 2'd2
   } state_t;

   state_t state, state_nx;

   // opnd holds the multiplicand or divisor; work_lo the multiplier/quotient;
   // work_hi the product high half / partial remainder.
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] opnd;
   logic [WIDTH-1:0] work_lo;
   logic [WIDTH-1:0] work_hi;

   logic load_single, load_mul, load_div, finish;

   // single-cycle datapath signals
   logic             sub;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;
   logic             cin_msb;
   logic             add_ovf;
   logic [WIDTH-1:0] s_res;
   logic [WIDTH-1:0] s_hi;
   logic             s_ovf;
   logic             s_cout;

   // iteration datapath signals
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic             div_ge;
   logic [WIDTH-1:0] div_diff;

   // adder shared by ADD/SUB and SLT; SLT always subtracts
   always_comb begin
      sub     = BNegate | (Operacioni == OP_SLT);
      b_eff   = B ^ {WIDTH{sub}};
      sum     = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
      // carry into the MSB recovered from the MSB sum bit and its two inputs
      cin_msb = A[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum[WIDTH-1];
      add_ovf = cin_msb ^ sum[WIDTH];
   end

   // results and flags for ops that complete on the accepting edge
   always_comb begin
      s_res  = '0;
      s_hi   = '0;
      s_ovf  = 1'b0;
      s_cout = 1'b0;
      case (Operacioni)
         OP_AND: s_res = A & B;
         OP_OR:  s_res = A | B;
         OP_ADD: begin
            s_res  = sum[WIDTH-1:0];
            s_ovf  = add_ovf;
            s_cout = sum[WIDTH];
         end
         OP_SLT: begin
            s_res  = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
            s_ovf  = add_ovf;
            s_cout = sum[WIDTH];
         end
         OP_DIV: begin
            // only reached for divide-by-zero
            s_res = '1;
            s_hi  = A;
            s_ovf = 1'b1;
         end
         OP_XOR: s_res = A ^ B;
         OP_NOR: s_res = ~(A | B);
         default: s_res = '0;
      endcase
   end

   // one shift-add step and one restoring-divide step
   always_comb begin
      mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
      div_shift = {work_hi, work_lo[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, opnd});
      // remainder stays below the divisor, so the low WIDTH bits are exact
      div_diff  = div_shift[WIDTH-1:0] - opnd;
   end

   // FSM state register
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) state <= IDLE;
      else       state <= state_nx;
   end

   // next-state and load/finish strobes
   always_comb begin
      state_nx    = state;
      load_single = 1'b0;
      load_mul    = 1'b0;
      load_div    = 1'b0;
      finish      = 1'b0;
      case (state)
         IDLE: begin
            if (Start) begin
               if (Operacioni == OP_MUL) begin
                  load_mul = 1'b1;
                  state_nx = MUL_RUN;
               end else if ((Operacioni == OP_DIV) && (B != '0)) begin
                  load_div = 1'b1;
                  state_nx = DIV_RUN;
               end else begin
                  load_single = 1'b1;
               end
            end
         end
         MUL_RUN, DIV_RUN: begin
            if (count == '0) begin
               finish   = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // iterative operand/accumulator registers and step counter
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         count   <= '0;
         opnd    <= '0;
         work_lo <= '0;
         work_hi <= '0;
      end else if (load_mul) begin
         opnd    <= A;
         work_lo <= B;
         work_hi <= '0;
         count   <= CW'(WIDTH);
      end else if (load_div) begin
         opnd    <= B;
         work_lo <= A;
         work_hi <= '0;
         count   <= CW'(WIDTH);
      end else if ((state == MUL_RUN) && (count != '0)) begin
         work_hi <= mul_sum[WIDTH:1];
         work_lo <= {mul_sum[0], work_lo[WIDTH-1:1]};
         count   <= count - 1'b1;
      end else if ((state == DIV_RUN) && (count != '0)) begin
         work_hi <= div_ge ? div_diff : div_shift[WIDTH-1:0];
         work_lo <= {work_lo[WIDTH-2:0], div_ge};
         count   <= count - 1'b1;
      end
   end

   // registered outputs: updated only on completion, Done pulses for one cycle
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         Busy     <= 1'b0;
         Done     <= 1'b0;
         Result   <= '0;
         ResultHi <= '0;
         Zero     <= 1'b0;
         Overflow <= 1'b0;
         CarryOut <= 1'b0;
      end else begin
         Done <= 1'b0;
         if (load_single) begin
            Done     <= 1'b1;
            Result   <= s_res;
            ResultHi <= s_hi;
            Zero     <= (s_res == '0);
            Overflow <= s_ovf;
            CarryOut <= s_cout;
         end else if (load_mul || load_div) begin
            Busy <= 1'b1;
         end else if (finish) begin
            Busy     <= 1'b0;
            Done     <= 1'b1;
            Result   <= work_lo;
            ResultHi <= work_hi;
            Zero     <= (work_lo == '0);
            Overflow <= (state == MUL_RUN) ? (work_hi != '0) : 1'b0;
            CarryOut <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq with a transaction-level reference model
module tb_alu_seq;
   localparam int W = 16;

   logic         clk   = 1'b0;
   logic         rst   = 1'b0;
   logic         start = 1'b0;
   logic         bneg  = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic [2:0]   op    = '0;

   logic         Busy, Done, Zero, Overflow, CarryOut;
   logic [W-1:0] Result, ResultHi;

   int n_chk  = 0;
   int n_fail = 0;

   alu_seq #(.WIDTH(W)) dut (
      .Clock(clk), .Reset(rst), .Start(start), .A(a), .B(b),
      .Operacioni(op), .BNegate(bneg), .Busy(Busy), .Done(Done),
      .Result(Result), .ResultHi(ResultHi), .Zero(Zero),
      .Overflow(Overflow), .CarryOut(CarryOut)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference arithmetic from the opcode rules, using plain integer maths
   task automatic model_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [2:0] iop,
                           input logic ineg, output logic [W-1:0] r, output logic [W-1:0] h,
                           output logic ov, output logic co);
      int sa, sb, t;
      logic [31:0] p;
      sa = $signed(ia);
      sb = $signed(ib);
      r = '0; h = '0; ov = 1'b0; co = 1'b0;
      case (iop)
         3'd0: r = ia & ib;
         3'd1: r = ia | ib;
         3'd2: begin
            if (ineg) begin
               r = ia - ib; t = sa - sb; co = (ia >= ib);
            end else begin
               r = ia + ib; t = sa + sb; co = ((32'(ia) + 32'(ib)) > 32'h0000FFFF);
            end
            ov = (t > 32767) || (t < -32768);
         end
         3'd3: begin
            t  = sa - sb;
            r  = (sa < sb) ? 16'd1 : 16'd0;
            co = (ia >= ib);
            ov = (t > 32767) || (t < -32768);
         end
         3'd4: begin
            p  = 32'(ia) * 32'(ib);
            r  = p[15:0];
            h  = p[31:16];
            ov = (h != 16'd0);
         end
         3'd5: begin
            if (ib == 16'd0) begin
               r = 16'hFFFF; h = ia; ov = 1'b1;
            end else begin
               r = ia / ib; h = ia % ib;
            end
         end
         3'd6: r = ia ^ ib;
         default: r = ~(ia | ib);
      endcase
   endtask

   // model state: what the outputs must be after each edge
   logic [W-1:0] m_res = '0, m_hi = '0, p_res = '0, p_hi = '0, t_r, t_h;
   logic         m_zero = 1'b0, m_ovf = 1'b0, m_cout = 1'b0, m_busy = 1'b0, m_done = 1'b0;
   logic         p_ovf = 1'b0, t_ov, t_co;
   int           remaining = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_res = '0; m_hi = '0; m_zero = 0; m_ovf = 0; m_cout = 0;
         m_busy = 0; m_done = 0; remaining = 0;
      end else begin
         m_done = 0;
         if (remaining > 0) begin
            remaining--;
            if (remaining == 0) begin
               m_res = p_res; m_hi = p_hi; m_zero = (p_res == '0);
               m_ovf = p_ovf; m_cout = 0; m_busy = 0; m_done = 1;
            end
         end else if (start) begin
            model_op(a, b, op, bneg, t_r, t_h, t_ov, t_co);
            if (op == 3'd4 || (op == 3'd5 && b != '0)) begin
               p_res = t_r; p_hi = t_h; p_ovf = t_ov;
               remaining = W + 1;
               m_busy = 1;
            end else begin
               m_res = t_r; m_hi = t_h; m_zero = (t_r == '0);
               m_ovf = t_ov; m_cout = t_co; m_done = 1;
            end
         end
      end
   end

   // compare every output against the model on each falling edge
   always @(negedge clk) begin
      check("cmp_busy",  32'(Busy),     32'(m_busy));
      check("cmp_done",  32'(Done),     32'(m_done));
      check("cmp_res",   32'(Result),   32'(m_res));
      check("cmp_hi",    32'(ResultHi), 32'(m_hi));
      check("cmp_zero",  32'(Zero),     32'(m_zero));
      check("cmp_ovf",   32'(Overflow), 32'(m_ovf));
      check("cmp_cout",  32'(CarryOut), 32'(m_cout));
   end

   task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [2:0] iop, input logic ineg);
      a = ia; b = ib; op = iop; bneg = ineg; start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
   endtask

   task automatic wait_done(input int from, output int lat);
      lat = from;
      while (Done !== 1'b1 && lat < 40) begin
         @(posedge clk); #2;
         lat++;
      end
   endtask

   typedef struct {
      logic [W-1:0] va;
      logic [W-1:0] vb;
      logic [2:0]   vop;
      logic         vneg;
   } vec_t;

   vec_t tbl[11] = '{
      '{16'hFFFF, 16'h0001, 3'd2, 1'b0},
      '{16'h8000, 16'h0001, 3'd2, 1'b1},
      '{16'h0002, 16'hFFFD, 3'd3, 1'b0},
      '{16'h0005, 16'h0003, 3'd3, 1'b1},
      '{16'hFFFF, 16'hFFFF, 3'd4, 1'b0},
      '{16'hFFFF, 16'h0001, 3'd5, 1'b0},
      '{16'h0003, 16'h0007, 3'd5, 1'b0},
      '{16'hF0F0, 16'h0FF0, 3'd0, 1'b0},
      '{16'hF0F0, 16'h0FF0, 3'd1, 1'b0},
      '{16'hF0F0, 16'h0FF0, 3'd6, 1'b0},
      '{16'h0000, 16'h0000, 3'd7, 1'b0}
   };

   initial begin
      int lat;
      int seen;
      #1 rst = 1'b1;
      #1;
      check("rst_busy", 32'(Busy), 32'd0);
      check("rst_done", 32'(Done), 32'd0);
      check("rst_res",  32'(Result), 32'd0);
      check("rst_hi",   32'(ResultHi), 32'd0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;

      // ADD with signed overflow
      issue(16'h7FFF, 16'h0001, 3'b010, 1'b0);
      check("add_done", 32'(Done), 32'd1);
      check("add_res",  32'(Result), 32'h8000);
      check("add_ovf",  32'(Overflow), 32'd1);
      check("add_cout", 32'(CarryOut), 32'd0);
      check("add_zero", 32'(Zero), 32'd0);
      @(posedge clk); #2;
      check("add_done_pulse", 32'(Done), 32'd0);

      // SUB to zero
      issue(16'h0005, 16'h0005, 3'b010, 1'b1);
      check("sub_res",  32'(Result), 32'h0000);
      check("sub_zero", 32'(Zero), 32'd1);
      check("sub_cout", 32'(CarryOut), 32'd1);
      check("sub_ovf",  32'(Overflow), 32'd0);

      // SLT -3 < 2
      issue(16'hFFFD, 16'h0002, 3'b011, 1'b0);
      check("slt_res", 32'(Result), 32'h0001);

      // MUL with an ignored Start while busy
      issue(16'h0100, 16'h0100, 3'b100, 1'b0);
      check("mul_busy", 32'(Busy), 32'd1);
      check("mul_hold", 32'(Result), 32'h0001);
      repeat (4) begin @(posedge clk); #2; end
      a = 16'h1111; b = 16'h2222; op = 3'b000; start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      wait_done(5, lat);
      check("mul_latency", 32'(lat), 32'd17);
      check("mul_res",  32'(Result), 32'h0000);
      check("mul_hi",   32'(ResultHi), 32'h0001);
      check("mul_zero", 32'(Zero), 32'd1);
      check("mul_ovf",  32'(Overflow), 32'd1);
      check("mul_busy_clr", 32'(Busy), 32'd0);

      // back-to-back: XOR started in the MUL Done cycle
      issue(16'hF0F0, 16'hFFFF, 3'b110, 1'b0);
      check("b2b_done", 32'(Done), 32'd1);
      check("b2b_res",  32'(Result), 32'h0F0F);
      check("b2b_hi",   32'(ResultHi), 32'h0000);

      // DIV 100 / 7
      issue(16'd100, 16'd7, 3'b101, 1'b0);
      wait_done(0, lat);
      check("div_latency", 32'(lat), 32'd17);
      check("div_res", 32'(Result), 32'd14);
      check("div_hi",  32'(ResultHi), 32'd2);
      check("div_ovf", 32'(Overflow), 32'd0);

      // divide by zero completes immediately
      issue(16'h1234, 16'h0000, 3'b101, 1'b0);
      check("dz_done", 32'(Done), 32'd1);
      check("dz_busy", 32'(Busy), 32'd0);
      check("dz_res",  32'(Result), 32'hFFFF);
      check("dz_hi",   32'(ResultHi), 32'h1234);
      check("dz_ovf",  32'(Overflow), 32'd1);
      check("dz_zero", 32'(Zero), 32'd0);

      // directed table checked through the model
      foreach (tbl[i]) begin
         issue(tbl[i].va, tbl[i].vb, tbl[i].vop, tbl[i].vneg);
         wait_done(0, lat);
         check("tbl_done", 32'(Done), 32'd1);
      end

      // asynchronous reset in the middle of a MUL
      issue(16'h0003, 16'h0005, 3'b100, 1'b0);
      repeat (5) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("abort_busy", 32'(Busy), 32'd0);
      check("abort_done", 32'(Done), 32'd0);
      check("abort_res",  32'(Result), 32'd0);
      check("abort_hi",   32'(ResultHi), 32'd0);
      check("abort_flags", 32'({Zero, Overflow, CarryOut}), 32'd0);
      @(posedge clk); #2 rst = 1'b0;
      seen = 0;
      repeat (25) begin
         @(posedge clk); #2;
         if (Done === 1'b1) seen++;
      end
      check("abort_no_done", 32'(seen), 32'd0);

      // fresh ADD after the abort
      issue(16'd3, 16'd4, 3'b010, 1'b0);
      check("post_done", 32'(Done), 32'd1);
      check("post_res",  32'(Result), 32'd7);

      repeat (2) @(posedge clk);
      #2;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
